// File: rtl/ufifo_wr_arb.sv
// Round-robin byte arbiter in front of a ufifo write port.
// Optional UFIFO_ARB_STATS_EN adds a saturating owner-stall counter.
module ufifo_wr_arb #(
    parameter int NREQ      = 4,
    parameter int MAX_BURST = 4,
    parameter int LGFLEN    = 2
) (
    input  logic              i_clk,
    input  logic              i_reset_n,
    input  logic [NREQ-1:0]   i_req,
    input  logic [NREQ-1:0]   i_last,
    input  logic [NREQ*8-1:0] i_data,
    output logic [NREQ-1:0]   o_ack,
    output logic [NREQ-1:0]   o_grant,
    input  logic [LGFLEN:0]   i_space,
    output logic              o_wr,
    output logic [7:0]        o_data
`ifdef UFIFO_ARB_STATS_EN
    ,
    output logic [15:0]       o_stall_cnt
`endif
);

    localparam int PW = $clog2(NREQ);
    localparam int CW = $clog2(MAX_BURST + 1);

    typedef enum logic {
        IDLE,
        OWN
    } state_t;

    state_t          state_q, state_d;
    logic [NREQ-1:0] grant_q, grant_d;
    logic [PW-1:0]   own_q, own_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            wr_q, wr_d;
    logic [7:0]      data_q, data_d;

    logic            pick_vld;
    logic [PW-1:0]   pick_idx;
    logic            own_req;
    logic            own_last;
    logic [7:0]      own_byte;
    logic            room;
    logic            ack_en;

    // own_q doubles as the round-robin pointer: search starts just past it
    always_comb begin
        logic [PW:0] sum;
        pick_vld = 1'b0;
        pick_idx = '0;
        sum      = '0;
        for (int i = 1; i <= NREQ; i++) begin
            sum = {1'b0, own_q} + (PW+1)'(i);
            if (sum >= (PW+1)'(NREQ)) begin
                sum = sum - (PW+1)'(NREQ);
            end
            if (!pick_vld && i_req[sum[PW-1:0]]) begin
                pick_vld = 1'b1;
                pick_idx = sum[PW-1:0];
            end
        end
    end

    assign own_req  = i_req[own_q];
    assign own_last = i_last[own_q];
    assign own_byte = i_data[{own_q, 3'b000} +: 8];
    // the write already in flight is not yet reflected in i_space
    assign room     = i_space > (LGFLEN+1)'(wr_q);
    assign ack_en   = (state_q == OWN) && own_req && room;

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        own_d   = own_q;
        cnt_d   = cnt_q;
        wr_d    = 1'b0;
        data_d  = data_q;
        unique case (state_q)
            IDLE: begin
                if (pick_vld) begin
                    state_d = OWN;
                    grant_d = NREQ'(1) << pick_idx;
                    own_d   = pick_idx;
                    cnt_d   = '0;
                end
            end
            OWN: begin
                if (ack_en) begin
                    wr_d   = 1'b1;
                    data_d = own_byte;
                    cnt_d  = cnt_q + CW'(1);
                    if (own_last || cnt_q == CW'(MAX_BURST - 1)) begin
                        state_d = IDLE;
                        grant_d = '0;
                    end
                end else if (!own_req) begin
                    state_d = IDLE;
                    grant_d = '0;
                end
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q <= IDLE;
            grant_q <= '0;
            own_q   <= PW'(NREQ - 1);
            cnt_q   <= '0;
            wr_q    <= 1'b0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            own_q   <= own_d;
            cnt_q   <= cnt_d;
            wr_q    <= wr_d;
            data_q  <= data_d;
        end
    end

    assign o_ack   = ack_en ? grant_q : '0;
    assign o_grant = grant_q;
    assign o_wr    = wr_q;
    assign o_data  = data_q;

`ifdef UFIFO_ARB_STATS_EN
    logic [15:0] stall_q, stall_d;

    always_comb begin
        stall_d = stall_q;
        if (state_q == OWN && own_req && !room && stall_q != 16'hFFFF) begin
            stall_d = stall_q + 16'd1;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign o_stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_ufifo_wr_arb.sv
// Bench for ufifo_wr_arb: vector table, directed sequences,
// and random traffic against a behavioural model.
module tb_ufifo_wr_arb;

    localparam int NREQ      = 4;
    localparam int MAX_BURST = 4;
    localparam int LGFLEN    = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  req, last, ack, grant;
    logic [31:0] data;
    logic [2:0]  space;
    logic        wr;
    logic [7:0]  dout;
`ifdef UFIFO_ARB_STATS_EN
    logic [15:0] stall_cnt;
`endif

    always #5 clk = ~clk;

    ufifo_wr_arb #(
        .NREQ(NREQ),
        .MAX_BURST(MAX_BURST),
        .LGFLEN(LGFLEN)
    ) dut (
        .i_clk(clk),
        .i_reset_n(rst_n),
        .i_req(req),
        .i_last(last),
        .i_data(data),
        .o_ack(ack),
        .o_grant(grant),
        .i_space(space),
        .o_wr(wr),
        .o_data(dout)
`ifdef UFIFO_ARB_STATS_EN
        ,
        .o_stall_cnt(stall_cnt)
`endif
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, got, exp, $time);
        end
    endtask

    // Behavioural model: owner index (-1 = nobody), last winner, burst size
    int         m_owner;
    int         m_rr;
    int         m_cnt;
    logic       m_wr;
    logic [7:0] m_data;
    int         m_stall;

    task automatic model_reset();
        m_owner = -1;
        m_rr    = NREQ - 1;
        m_cnt   = 0;
        m_wr    = 1'b0;
        m_data  = 8'h00;
        m_stall = 0;
    endtask

    function automatic logic [3:0] m_ack();
        logic [3:0] a;
        a = '0;
        if (m_owner >= 0 && req[m_owner] && int'(space) > int'(m_wr))
            a[m_owner] = 1'b1;
        return a;
    endfunction

    function automatic logic [3:0] m_grant();
        logic [3:0] g;
        g = '0;
        if (m_owner >= 0) g[m_owner] = 1'b1;
        return g;
    endfunction

    task automatic model_step();
        logic [3:0] a;
        bit found;
        int k;
        a = m_ack();
        if (m_owner < 0) begin
            m_wr  = 1'b0;
            found = 0;
            for (int i = 1; i <= NREQ; i++) begin
                k = (m_rr + i) % NREQ;
                if (!found && req[k]) begin
                    found   = 1;
                    m_owner = k;
                    m_rr    = k;
                    m_cnt   = 0;
                end
            end
        end else if (a != 0) begin
            m_wr   = 1'b1;
            m_data = data[8*m_owner +: 8];
            m_cnt++;
            if (last[m_owner] || m_cnt == MAX_BURST) m_owner = -1;
        end else begin
            m_wr = 1'b0;
            if (req[m_owner]) begin
                if (m_stall < 65535) m_stall++;
            end else begin
                m_owner = -1;
            end
        end
    endtask

    task automatic check_model(input string tag);
        chk({tag, ".grant"}, grant, m_grant());
        chk({tag, ".ack"}, ack, m_ack());
        chk({tag, ".wr"}, wr, m_wr);
        chk({tag, ".data"}, dout, m_data);
`ifdef UFIFO_ARB_STATS_EN
        chk({tag, ".stall"}, stall_cnt, m_stall);
`endif
    endtask

    task automatic drive(input logic [3:0] r, input logic [3:0] l,
                         input logic [31:0] d, input logic [2:0] s);
        req   = r;
        last  = l;
        data  = d;
        space = s;
    endtask

    // Inputs already driven just after a falling edge; check, advance.
    task automatic cycle(input string tag);
        #1;
        check_model(tag);
        model_step();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        drive(4'b0, 4'b0, 32'b0, 3'd0);
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic [3:0]  req;
        logic [3:0]  last;
        logic [31:0] data;
        logic [2:0]  space;
        logic [3:0]  grant;
        logic [3:0]  ack;
        logic        wr;
        logic [7:0]  dout;
    } vec_t;

    vec_t tbl[12];

    logic [3:0] ghist[16];
    logic       whist[16];
    logic [9:0] wpat;
    int         order[$];

    initial begin
        tbl[0]  = '{4'b0001, 4'b0001, 32'h0000_00A5, 3'd3, 4'b0000, 4'b0000, 1'b0, 8'h00};
        tbl[1]  = '{4'b0001, 4'b0001, 32'h0000_00A5, 3'd3, 4'b0001, 4'b0001, 1'b0, 8'h00};
        tbl[2]  = '{4'b0000, 4'b0000, 32'h0000_00A5, 3'd3, 4'b0000, 4'b0000, 1'b1, 8'hA5};
        tbl[3]  = '{4'b0000, 4'b0000, 32'h0000_0000, 3'd3, 4'b0000, 4'b0000, 1'b0, 8'hA5};
        tbl[4]  = '{4'b0010, 4'b0000, 32'h0000_1100, 3'd1, 4'b0000, 4'b0000, 1'b0, 8'hA5};
        tbl[5]  = '{4'b0010, 4'b0000, 32'h0000_1100, 3'd1, 4'b0010, 4'b0010, 1'b0, 8'hA5};
        tbl[6]  = '{4'b0010, 4'b0000, 32'h0000_2200, 3'd1, 4'b0010, 4'b0000, 1'b1, 8'h11};
        tbl[7]  = '{4'b0010, 4'b0000, 32'h0000_2200, 3'd2, 4'b0010, 4'b0010, 1'b0, 8'h11};
        tbl[8]  = '{4'b0010, 4'b0000, 32'h0000_3300, 3'd2, 4'b0010, 4'b0010, 1'b1, 8'h22};
        tbl[9]  = '{4'b0010, 4'b0000, 32'h0000_4400, 3'd0, 4'b0010, 4'b0000, 1'b1, 8'h33};
        tbl[10] = '{4'b0010, 4'b0010, 32'h0000_4400, 3'd3, 4'b0010, 4'b0010, 1'b0, 8'h33};
        tbl[11] = '{4'b0000, 4'b0000, 32'h0000_0000, 3'd3, 4'b0000, 4'b0000, 1'b1, 8'h44};

        // vector table: single-byte packet, then space-throttled owner 1
        do_reset();
        for (int i = 0; i < 12; i++) begin
            drive(tbl[i].req, tbl[i].last, tbl[i].data, tbl[i].space);
            #1;
            chk($sformatf("tbl%0d.grant", i), grant, tbl[i].grant);
            chk($sformatf("tbl%0d.ack", i), ack, tbl[i].ack);
            chk($sformatf("tbl%0d.wr", i), wr, tbl[i].wr);
            chk($sformatf("tbl%0d.data", i), dout, tbl[i].dout);
            @(negedge clk);
        end
`ifdef UFIFO_ARB_STATS_EN
        chk("tbl.stall", stall_cnt, 32'd2);
`endif

        // req0 + req2 persistent, no last: bursts of MAX_BURST
        do_reset();
        for (int c = 0; c < 12; c++) begin
            drive(4'b0101, 4'b0000, $urandom, 3'd4);
            #1;
            ghist[c] = grant;
            whist[c] = wr;
            check_model("burst");
            model_step();
            @(negedge clk);
        end
        for (int c = 0; c < 10; c++) wpat[9-c] = whist[c+2];
        chk("burst.wr_pattern", wpat, 10'b1111011110);
        chk("burst.grant1", ghist[1], 4'b0001);
        chk("burst.grant6", ghist[6], 4'b0100);
        chk("burst.grant11", ghist[11], 4'b0001);

        // all four requesting single-byte packets: strict rotation
        do_reset();
        order.delete();
        for (int c = 0; c < 14; c++) begin
            drive(4'b1111, 4'b1111, $urandom, 3'd4);
            #1;
            for (int k = 0; k < NREQ; k++)
                if (ack[k]) order.push_back(k);
            check_model("rr");
            model_step();
            @(negedge clk);
        end
        chk("rr.count_ge5", 32'(order.size() >= 5), 32'd1);
        if (order.size() >= 5) begin
            chk("rr.order0", order[0], 0);
            chk("rr.order1", order[1], 1);
            chk("rr.order2", order[2], 2);
            chk("rr.order3", order[3], 3);
            chk("rr.order4", order[4], 0);
        end

        // owner 3 abandons its burst after two bytes
        do_reset();
        for (int c = 0; c < 7; c++) begin
            if (c < 3) drive(4'b1000, 4'b0000, $urandom, 3'd4);
            else       drive(4'b0001, 4'b0000, $urandom, 3'd4);
            #1;
            if (c == 4) chk("drop.no_wr", wr, 1'b0);
            if (c == 4) chk("drop.idle", grant, 4'b0000);
            if (c == 5) chk("drop.grant0", grant, 4'b0001);
            check_model("drop");
            model_step();
            @(negedge clk);
        end

        // asynchronous reset while a write is in flight
        do_reset();
        for (int c = 0; c < 3; c++) begin
            drive(4'b0001, 4'b0000, 32'h0000_005A, 3'd4);
            cycle("prerst");
        end
        drive(4'b0001, 4'b0000, 32'h0000_005A, 3'd4);
        #1;
        chk("prerst.wr_high", wr, 1'b1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("rst.wr", wr, 1'b0);
        chk("rst.grant", grant, 4'b0000);
        chk("rst.data", dout, 8'h00);
`ifdef UFIFO_ARB_STATS_EN
        chk("rst.stall", stall_cnt, 32'd0);
`endif
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            drive(4'b1111, 4'b0000, $urandom, 3'd4);
            #1;
            if (c == 1) chk("rst.first_grant", grant, 4'b0001);
            check_model("postrst");
            model_step();
            @(negedge clk);
        end

        // random traffic, including zero space at reset release
        do_reset();
        for (int c = 0; c < 1500; c++) begin
            drive(4'($urandom), 4'($urandom_range(0, 15) < 4 ? 4'hF : 4'h0),
                  $urandom, 3'($urandom_range(0, 4)));
            cycle("rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
